// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg: segment patterns, digit count and shared types for the display driver
package calc_disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_R     = 7'b1010000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  typedef logic [1:0] scan_idx_t;
  typedef enum logic [2:0] {SM_DIGIT, SM_DASH, SM_E, SM_R, SM_BLANK} seg_mode_t;
  typedef struct packed {
    logic [15:0] bcd;
    logic        neg;
    logic        err;
  } disp_t;
endpackage

// File: rtl/calc_seg_enc.sv
// calc_seg_enc: combinational nibble/mode to active-high seven-segment pattern
module calc_seg_enc
  import calc_disp_pkg::*;
(
  input  logic [3:0] nib,
  input  seg_mode_t  mode,
  output logic [6:0] pat
);
  logic [6:0] dig;
  always_comb begin
    case (nib)
      4'd0:    dig = SEG_0;
      4'd1:    dig = SEG_1;
      4'd2:    dig = SEG_2;
      4'd3:    dig = SEG_3;
      4'd4:    dig = SEG_4;
      4'd5:    dig = SEG_5;
      4'd6:    dig = SEG_6;
      4'd7:    dig = SEG_7;
      4'd8:    dig = SEG_8;
      4'd9:    dig = SEG_9;
      default: dig = SEG_DASH;
    endcase
    pat = mode == SM_DIGIT ? dig :
          mode == SM_DASH  ? SEG_DASH :
          mode == SM_E     ? SEG_E :
          mode == SM_R     ? SEG_R : SEG_BLANK;
  end
endmodule

// File: rtl/calc_disp_scan.sv
// calc_disp_scan: multiplexed 4-digit seven-segment driver with tear-free frame capture
module calc_disp_scan
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        neg,
  input  logic        err,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
  localparam logic [3:0] AN_OFF = AN_ACTIVE_LOW != 0 ? 4'hf : 4'h0;
  localparam logic DP_OFF = SEG_ACTIVE_LOW != 0;
  logic [CW-1:0] cnt;
  scan_idx_t idx, nxt_idx;
  logic live, tc, fb;
  disp_t cap, shadow, disp, disp_nxt;
  logic [2:0] k, di;
  logic [3:0] nib, oh;
  seg_mode_t mode;
  logic [6:0] pat;
  // Outputs are computed for the digit about to be shown, from the value that
  // will be in the display register once this edge commits.
  always_comb begin
    tc = cnt == CW'(REFRESH_DIV - 1);
    nxt_idx = live ? idx + 2'd1 : 2'd0;
    fb = tc && (idx == 2'd3 || !live);
    cap = {bcd_in, neg, err};
    disp_nxt = fb ? (load ? cap : shadow) : disp;
    k = |disp_nxt.bcd[15:12] ? 3'd4 :
        |disp_nxt.bcd[11:8]  ? 3'd3 :
        |disp_nxt.bcd[7:4]   ? 3'd2 : 3'd1;
    di = {1'b0, nxt_idx};
    nib = disp_nxt.bcd[{nxt_idx, 2'b00} +: 4];
    oh = 4'b0001 << nxt_idx;
    mode = (disp_nxt.err || (disp_nxt.neg && k == 3'd4)) ?
             (di == 3'd3 ? SM_E : di == 3'd0 ? SM_BLANK : SM_R) :
           disp_nxt.neg ? (di == k ? SM_DASH : di > k ? SM_BLANK : SM_DIGIT) :
           (blank_lz && di >= k && di != 3'd0) ? SM_BLANK : SM_DIGIT;
  end
  calc_seg_enc u_enc (.nib(nib), .mode(mode), .pat(pat));
  always_ff @(posedge clk) begin
    dp <= DP_OFF;
    if (!resetn) begin
      cnt <= '0;
      idx <= '0;
      live <= 1'b0;
      shadow <= '0;
      disp <= '0;
      seg <= SEG_OFF;
      an <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (load) shadow <= cap;
      disp <= disp_nxt;
      frame_done <= fb;
      if (tc) begin
        idx <= nxt_idx;
        live <= 1'b1;
        seg <= SEG_ACTIVE_LOW != 0 ? ~pat : pat;
        an <= AN_ACTIVE_LOW != 0 ? ~oh : oh;
      end
    end
  end
endmodule

// File: tb/tb_calc_disp_scan.sv
// tb_calc_disp_scan: directed vectors for scan, blanking, sign, error, tearing and reset
module tb_calc_disp_scan;
  logic clk = 1'b0;
  logic resetn, load, neg, err, blank_lz, dp, frame_done;
  logic [15:0] bcd_in;
  logic [6:0] seg;
  logic [3:0] an;
  logic [6:0] fr [4];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  calc_disp_scan #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .resetn(resetn), .load(load), .bcd_in(bcd_in), .neg(neg), .err(err),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_load(input logic [15:0] b, input logic n, input logic e);
    bcd_in = b;
    neg = n;
    err = e;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    check("frame_done_seen", frame_done, 1);
  endtask
  task automatic grab_frame();
    logic [3:0] e;
    wait_fd();
    for (int j = 0; j < 4; j++) begin
      if (j > 0) repeat (4) @(negedge clk);
      e = ~(4'b0001 << j);
      check("scan_an", an, e);
      fr[j] = seg;
    end
  endtask
  initial begin
    resetn = 1'b0;
    load = 1'b0;
    bcd_in = '0;
    neg = 1'b0;
    err = 1'b0;
    blank_lz = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_fd", frame_done, 0);
    check("rst_dp", dp, 1);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_tc_an", an, 4'b1111);
    @(negedge clk);
    check("first_an", an, 4'b1110);
    check("first_seg", seg, 7'b1000000);
    check("first_dp", dp, 1);
    do_load(16'h0042, 1'b0, 1'b0);
    grab_frame();
    check("lz_d0", fr[0], 7'b0100100);
    check("lz_d1", fr[1], 7'b0011001);
    check("lz_d2", fr[2], 7'b1111111);
    check("lz_d3", fr[3], 7'b1111111);
    blank_lz = 1'b0;
    grab_frame();
    check("nolz_d0", fr[0], 7'b0100100);
    check("nolz_d1", fr[1], 7'b0011001);
    check("nolz_d2", fr[2], 7'b1000000);
    check("nolz_d3", fr[3], 7'b1000000);
    do_load(16'h0042, 1'b1, 1'b0);
    grab_frame();
    check("neg_d0", fr[0], 7'b0100100);
    check("neg_d1", fr[1], 7'b0011001);
    check("neg_d2", fr[2], 7'b0111111);
    check("neg_d3", fr[3], 7'b1111111);
    do_load(16'h1234, 1'b1, 1'b0);
    grab_frame();
    check("ovf_d0", fr[0], 7'b1111111);
    check("ovf_d1", fr[1], 7'b0101111);
    check("ovf_d2", fr[2], 7'b0101111);
    check("ovf_d3", fr[3], 7'b0000110);
    do_load(16'h5678, 1'b0, 1'b1);
    grab_frame();
    check("err_d0", fr[0], 7'b1111111);
    check("err_d1", fr[1], 7'b0101111);
    check("err_d2", fr[2], 7'b0101111);
    check("err_d3", fr[3], 7'b0000110);
    wait_fd();
    repeat (4) @(negedge clk);
    check("tear_slot1_an", an, 4'b1101);
    do_load(16'h1111, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("tear_d2_an", an, 4'b1011);
    check("tear_d2_seg", seg, 7'b0101111);
    repeat (4) @(negedge clk);
    check("tear_d3_an", an, 4'b0111);
    check("tear_d3_seg", seg, 7'b0000110);
    repeat (4) @(negedge clk);
    check("tear_fd", frame_done, 1);
    check("tear_new_an", an, 4'b1110);
    check("tear_new_seg", seg, 7'b1111001);
    repeat (12) @(negedge clk);
    check("byp_slot3_an", an, 4'b0111);
    repeat (3) @(negedge clk);
    do_load(16'h0009, 1'b0, 1'b0);
    check("byp_fd", frame_done, 1);
    check("byp_an", an, 4'b1110);
    check("byp_seg", seg, 7'b0010000);
    repeat (8) @(negedge clk);
    check("mid_slot2_an", an, 4'b1011);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("mid_rst_an", an, 4'b1111);
    check("mid_rst_seg", seg, 7'b1111111);
    check("mid_rst_fd", frame_done, 0);
    repeat (3) @(negedge clk);
    check("mid_wait_an", an, 4'b1111);
    @(negedge clk);
    check("mid_restart_an", an, 4'b1110);
    check("mid_restart_seg", seg, 7'b1000000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_disp_scan.md
# calc_disp_scan

Multiplexed 4-digit seven-segment display driver for the keypad calculator; it is the output side of the user interface, where the keypad scanner is the input side. It captures a 16-bit BCD result with sign and error flags from the datapath and shows it without tearing. It time-multiplexes the digits with a prescaled one-hot anode scan, blanks leading zeros, places a minus sign and renders an error pattern.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥1.
- SEG_ACTIVE_LOW, 1: 1 means `seg`/`dp` are driven inverted.
- AN_ACTIVE_LOW, 1: 1 means `an` is driven inverted.

- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- load  in  1  one-cycle strobe that captures `bcd_in`, `neg` and `err` into the shadow register.
- bcd_in  in  16  four BCD digits, [15:12] is the most significant.
- neg  in  1  value is negative (ALU `special_signal`).
- err  in  1  show the error pattern.
- blank_lz  in  1  leading-zero blanking enable.
- seg  out  7  {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, always off.
- an  out  4  one-hot digit enable; bit i selects digit i.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Shadow register holds {bcd, neg, err}. It is written on any cycle with `load`=1.
- Display register takes the shadow value at each frame boundary, so the value shown never changes mid-frame.
- If `load`=1 in the same cycle as a frame boundary, the new inputs bypass the shadow into the display register.
- Prescaler counts 0..REFRESH_DIV-1. At terminal count the scan index advances 0→1→2→3→0.
- Significant-digit count k = index of the highest nonzero digit + 1, with a minimum of 1.
- Digit i is rendered as follows, evaluated in priority order:
  - err=1: digit3 shows 'E', digit2 'r', digit1 'r', digit0 is blank.
  - neg=1 and k=4: same as the error pattern (value does not fit).
  - neg=1 and k≤3: digit k shows a dash. Digits above k are blank. Leading-zero blanking is forced on.
  - blank_lz=1: digits at index ≥k are blank.
  - Otherwise the digit shows its nibble.
- Digit 0 is never blanked by leading-zero logic.
- Nibbles 10..15 render as a dash.
- Logical patterns (active-high):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - dash=1000000, E=1111001, r=1010000, blank=0000000
- Polarity parameters are applied last, at the output registers.

## Timing
- All outputs are registered.
- Reset values: `an` all inactive, `seg` all off, `dp` off, `frame_done`=0, prescaler=0, scan index=0, shadow=0, display register=0.
- After reset is released, the first terminal count (REFRESH_DIV cycles later) drives `an` to digit 0 with the digit-0 pattern. From then on exactly one anode is active.
- `seg` and `an` change on the same edge, one cycle after the terminal count. No cycle has a new anode with a stale segment pattern.
- The frame boundary is the terminal count while index=3. `frame_done` is asserted in the cycle the digit-0 outputs appear, and the display register is updated in that same cycle.
- Load-to-visible latency: from the next frame boundary at most 4·REFRESH_DIV cycles; 0 extra cycles on a coincident boundary.
- `resetn`=0 mid-frame returns every register to its reset value at the next edge.

## Structure
- Package `calc_disp_pkg` holds:
  - localparams for the segment patterns (SEG_0..SEG_9, SEG_DASH, SEG_E, SEG_R, SEG_BLANK);
  - NUM_DIGITS=4;
  - a 2-bit typedef for the scan index.
- Sub-module `calc_seg_enc` is purely combinational: inputs are a nibble and a mode {digit, dash, E, r, blank}; output is the logical 7-bit pattern.
- The top module contains the prescaler, scan ring, shadow and display registers, the k/priority logic and the polarity output registers.

## Test plan
All scenarios use REFRESH_DIV=4, SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1.
- Reset: hold resetn=0 for 3 cycles → an=1111, seg=1111111, frame_done=0. Release → 4 cycles later an=1110 and seg=1000000 ('0').
- Blanking: load bcd=0x0042, blank_lz=1 → after the next frame_done, digit0=0100100 ('2'), digit1=0011001 ('4'), an=1011 and an=0111 show seg=1111111. Repeat with blank_lz=0 → digits 2 and 3 show '0'.
- Sign: load 0x0042 with neg=1 → digit2 shows 0111111 (dash) and digit3 is blank. Load 0x1234 with neg=1 → E, r, r, blank.
- Error: load err=1 with any bcd → digit3=0000110 ('E'), digit2 and digit1=0101111 ('r'), digit0 blank.
- Tearing and bypass: load 0x1111 at slot 1 of a frame → digits 2 and 3 of that frame still show the old value, and the new value appears from frame_done. Load coincident with the frame-boundary cycle → the new value is shown on digit 0 of the same frame.
- Mid-frame reset: resetn=0 for one cycle while index=2 → next cycle an=1111 and seg off. Scan restarts at digit 0 after REFRESH_DIV cycles, showing '0'.
